if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the in-order pipeline. It owns the PC, drives a single-outstanding SRAM-like instruction port and holds the IF/ID register consumed by decode. It consumes `stall` and `flush` from the pipeline controller, plus branch redirects from decode. Wrong-path fetches are cancelled after a flush or a taken branch, and a one-entry skid buffer absorbs responses that arrive while decode is stalled.

## Interface
- `RESET_PC`, default 32'h1c000000: first fetch address after reset.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 6: pipeline stall vector. Bit 0 blocks issue of new fetches; bit 1 holds the IF/ID register. Other bits are ignored.
- `flush` in 1: exception or return redirect. Has priority over everything except `reset`.
- `flush_pc` in 32: redirect target when `flush`=1.
- `br_taken` in 1: the instruction currently in IF/ID is a taken branch.
- `br_target` in 32: branch target.
- `inst_req` out 1: fetch request.
- `inst_addr` out 32: fetch address. Stable while `inst_req`=1.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: response valid this cycle.
- `inst_rdata` in 32: response word.
- `fs_valid` out 1: IF/ID register holds an instruction.
- `fs_pc` out 32: PC of the IF/ID instruction.
- `fs_inst` out 32: IF/ID instruction word.

## Operation
**State.**
- FSM states: IDLE, REQ, WAIT.
- `pc_next` (32b): address of the next fetch.
- `discard` (1b): drop the next response.
- Skid buffer B: `b_valid`, `b_pc`, `b_inst`.
- IF/ID register O: `fs_*`.

**Reset.** All of the following hold while reset is asserted:
- state=IDLE, `pc_next`=RESET_PC, `discard`=0, `b_valid`=0.
- `fs_valid`=0, `fs_pc`=0, `fs_inst`=0.
- `inst_req`=0, `inst_addr`=RESET_PC.

**FSM.**
- IDLE: `inst_req`=0. Go to REQ when `b_valid`=0 and `stall[0]`=0.
- REQ: `inst_req`=1, `inst_addr`=`pc_next`. Request stays high with a stable address until `inst_addr_ok`; no redirect withdraws it. On `inst_addr_ok`, go to WAIT and set `pc_next`+=4 unless a redirect occurs this cycle.
- WAIT: `inst_req`=0. On `inst_data_ok`, go to REQ if the response was not written into B and `stall[0]`=0; otherwise go to IDLE.
- At most one request is outstanding at any time.
- `inst_data_ok` outside WAIT is a protocol violation and is ignored.

**Redirect.** A redirect is `flush`, or `br_taken` & `!stall[1]`. `br_taken` with `stall[1]`=1 is ignored; decode reasserts it.
- `pc_next` <= target (`flush_pc` has priority over `br_target`).
- O and B are invalidated next cycle. A flush overrides `stall[1]`.
- `discard` <= 1 if state is WAIT without `inst_data_ok` this cycle, or state is REQ (accepted or not).
- A response arriving in the same cycle as a redirect is dropped and does not set `discard`.
- A response with `discard`=1 is dropped, clears `discard`, and writes neither O nor B.

**Data path** (no redirect this cycle, response R kept):
- `stall[1]`=0: O <= B if `b_valid`, else R if present, else bubble (`fs_valid`=0). If B was valid and R is present, B <= R; otherwise B empties.
- `stall[1]`=1: O holds. R, if present, goes into B.
- B is never overwritten while valid. Issue is gated on `b_valid`=0, so B cannot overflow.

## Timing
- Ideal memory (`addr_ok` in the REQ cycle, `data_ok` the next cycle): first instruction in O 3 cycles after reset deasserts (IDLE, REQ, WAIT). Steady state: one instruction every 2 cycles.
- Redirect: the first target fetch is requested in the cycle after the redirect, or in the cycle after the discarded response if one is still outstanding.
- O updates only at the clock edge; `fs_*` are registered.
- Reset asserted mid-transaction drops all state in the same edge. A response to a pre-reset request that arrives after reset (while IDLE) is ignored.

## Test plan
- Reset release with ideal memory returning `addr+0x100` as data → `inst_addr` sequence 1c000000, 1c000004, 1c000008. O shows pc 1c000000 / inst 1c000100 on the 3rd cycle after release, then a new instruction every 2 cycles.
- `stall`=6'b000011 held 6 cycles → O frozen, B captures exactly one response, no further `inst_req`. On release O takes the B contents and fetching resumes in order with no loss or duplication.
- `flush`=1, `flush_pc`=1c008000 while in WAIT → next `data_ok` is dropped, `fs_valid`=0, next `inst_addr`=1c008000.
- `br_taken` to 1c000040 in the same cycle as `inst_addr_ok` for 1c00000c → 1c00000c response is dropped, then 1c000040 is fetched and appears in O.
- `flush` while REQ is pending with `addr_ok` held low for 3 cycles → `inst_addr` stays at the old value until accepted, that response is dropped, then the `flush_pc` fetch follows.
- `reset` asserted during WAIT, with `data_ok` arriving 1 cycle after release → `fs_valid`=0 and the first post-reset `inst_addr`=RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: single-outstanding request/accept
// handshake followed by a data_ok response carrying the fetched word.
interface if_stage_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time, cancels
// wrong-path responses after a redirect and parks stalled responses in a skid buffer.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   if_stage_if.master  imem,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_next, pc_nx;
   logic [31:0] addr_q;
   logic        discard;
   logic        b_valid;
   logic [31:0] b_pc, b_inst;
   logic        redirect, resp, keep, to_b;
   logic [31:0] target;
   logic        unused_stall;

   assign unused_stall = ^stall[5:2];

   assign redirect = flush | (br_taken & ~stall[1]);
   assign target   = flush ? flush_pc : br_target;
   assign resp     = (state == WAIT) & imem.inst_data_ok;
   assign keep     = resp & ~discard & ~redirect;
   assign to_b     = keep & (stall[1] | b_valid);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if ((~b_valid | redirect) & ~stall[0]) state_nx = REQ;
         REQ:  if (imem.inst_addr_ok) state_nx = WAIT;
         WAIT: if (resp) state_nx = (~to_b & ~stall[0]) ? REQ : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      imem.inst_req = 1'b0;
      if (state == REQ) imem.inst_req = 1'b1;
   end

   assign imem.inst_addr = addr_q;

   // A request accepted after a redirect is wrong-path, so it must not advance the PC.
   always_comb begin
      if (redirect)
         pc_nx = target;
      else if ((state == REQ) & imem.inst_addr_ok & ~discard)
         pc_nx = pc_next + 32'd4;
      else
         pc_nx = pc_next;
   end

   // addr_q is latched on REQ entry and kept through WAIT, so it also names the in-flight PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_next <= RESET_PC;
         addr_q  <= RESET_PC;
         discard <= 1'b0;
      end else begin
         pc_next <= pc_nx;
         if ((state != REQ) && (state_nx == REQ)) addr_q <= pc_nx;
         if (redirect)
            discard <= (state == REQ) | ((state == WAIT) & ~imem.inst_data_ok);
         else if (resp)
            discard <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid <= 1'b0;
         fs_pc    <= '0;
         fs_inst  <= '0;
         b_valid  <= 1'b0;
         b_pc     <= '0;
         b_inst   <= '0;
      end else if (redirect) begin
         fs_valid <= 1'b0;
         b_valid  <= 1'b0;
      end else begin
         if (~stall[1]) begin
            fs_valid <= b_valid | keep;
            if (b_valid) begin
               fs_pc   <= b_pc;
               fs_inst <= b_inst;
            end else if (keep) begin
               fs_pc   <= addr_q;
               fs_inst <= imem.inst_rdata;
            end
            b_valid <= to_b;
         end else if (keep) begin
            b_valid <= 1'b1;
         end
         if (to_b) begin
            b_pc   <= addr_q;
            b_inst <= imem.inst_rdata;
         end
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// program-order fetch model and a single-outstanding memory model.
module tb_if_stage;
   localparam logic [31:0] RPC = 32'h1c000000;
   localparam logic [31:0] FPC = 32'h1c008000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_valid;
   logic [31:0] fs_pc, fs_inst;

   if_stage_if bus ();

   if_stage #(.RESET_PC(RPC)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .br_taken  (br_taken),
      .br_target (br_target),
      .imem      (bus),
      .fs_valid  (fs_valid),
      .fs_pc     (fs_pc),
      .fs_inst   (fs_inst)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // memory model
   bit          m_pend;
   logic [31:0] m_addr;
   int          m_delay;
   int          m_cfg_delay;
   bit          m_accept_all;
   bit          m_block;
   logic [31:0] acc_q[$];

   // program-order model of what decode should consume
   logic [31:0] exp_pc;
   bit          cons;
   logic [31:0] cons_pc, cons_inst, cons_exp;
   int          n_cons = 0;

   bit          viol_out, viol_addr;
   bit          prev_pend_req;
   logic [31:0] prev_addr;
   bit          s_req;

   task automatic step(input bit rst, input logic [5:0] st, input bit fl,
                       input logic [31:0] fpc, input bit bt, input logic [31:0] btgt);
      bit ao, dok;
      logic [31:0] a;
      a   = bus.inst_addr;
      ao  = bus.inst_req && !m_block && (m_accept_all || ($urandom_range(0, 2) != 0));
      dok = m_pend && (m_delay == 0);
      viol_out  = bus.inst_req && m_pend;
      viol_addr = prev_pend_req && (!bus.inst_req || (a !== prev_addr));
      s_req = bus.inst_req;
      reset = rst; stall = st; flush = fl; flush_pc = fpc; br_taken = bt; br_target = btgt;
      bus.inst_addr_ok = ao;
      bus.inst_data_ok = dok;
      bus.inst_rdata   = dok ? (m_addr + 32'h100) : $urandom;
      cons = 1'b0;
      if (rst) exp_pc = RPC;
      else if (fl) exp_pc = fpc;
      else if (fs_valid && !st[1]) begin
         cons = 1'b1; cons_pc = fs_pc; cons_inst = fs_inst; cons_exp = exp_pc;
         n_cons++;
         exp_pc = bt ? btgt : exp_pc + 32'd4;
      end
      if (ao) acc_q.push_back(a);
      @(posedge clk);
      if (dok) m_pend = 1'b0;
      else if (m_pend) m_delay--;
      if (ao) begin
         m_pend = 1'b1; m_addr = a;
         m_delay = (m_cfg_delay < 0) ? $urandom_range(0, 3) : m_cfg_delay;
      end
      prev_pend_req = s_req && !ao;
      prev_addr = a;
      @(negedge clk);
   endtask

   task automatic idle(input logic [5:0] st);
      step(1'b0, st, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic do_reset();
      m_block = 1'b0;
      step(1'b1, '0, 1'b0, '0, 1'b0, '0);
      step(1'b1, '0, 1'b0, '0, 1'b0, '0);
      m_pend = 1'b0;
      prev_pend_req = 1'b0;
      acc_q.delete();
   endtask

   task automatic wait_req(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (bus.inst_req) begin ok = 1'b1; break; end
         idle('0);
      end
   endtask

   task automatic wait_valid(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (fs_valid) begin ok = 1'b1; break; end
         idle('0);
      end
   endtask

   task automatic test_reset();
      m_accept_all = 1'b1; m_cfg_delay = 0;
      do_reset();
      checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus.inst_req); end
      checks++; if (bus.inst_addr !== RPC) begin failures++; $display("FAIL reset_addr: got %h expected %h", bus.inst_addr, RPC); end
      checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", fs_valid); end
      checks++; if (fs_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", fs_pc); end
      checks++; if (fs_inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0", fs_inst); end
   endtask

   task automatic test_ideal();
      bit ev;
      logic [31:0] epc;
      m_accept_all = 1'b1; m_cfg_delay = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         ev = (c >= 3) && (c % 2 == 1);
         checks++;
         if (fs_valid !== ev) begin failures++; $display("FAIL ideal_valid c%0d: got %b expected %b", c, fs_valid, ev); end
         if (ev) begin
            epc = RPC + 32'(4 * ((c - 3) / 2));
            checks++;
            if (fs_pc !== epc) begin failures++; $display("FAIL ideal_pc c%0d: got %h expected %h", c, fs_pc, epc); end
            checks++;
            if (fs_inst !== epc + 32'h100) begin failures++; $display("FAIL ideal_inst c%0d: got %h expected %h", c, fs_inst, epc + 32'h100); end
         end
         idle('0);
      end
      checks++;
      if (acc_q.size() < 3) begin failures++; $display("FAIL ideal_nreq: got %0d expected >=3", acc_q.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_q[i] !== RPC + 32'(4 * i)) begin failures++; $display("FAIL ideal_addr%0d: got %h expected %h", i, acc_q[i], RPC + 32'(4 * i)); end
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      int reqs;
      logic [31:0] frozen;
      m_accept_all = 1'b1; m_cfg_delay = 0;
      do_reset();
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_first: got timeout expected valid"); end
      frozen = fs_pc;
      reqs = 0;
      for (int k = 0; k < 6; k++) begin
         idle(6'b000011);
         if (k >= 1 && s_req) reqs++;
         checks++;
         if (fs_valid !== 1'b1 || fs_pc !== frozen) begin failures++; $display("FAIL stall_hold k%0d: got %b/%h expected 1/%h", k, fs_valid, fs_pc, frozen); end
      end
      checks++; if (reqs !== 0) begin failures++; $display("FAIL stall_noreq: got %0d expected 0", reqs); end
      idle('0);
      checks++; if (fs_valid !== 1'b1 || fs_pc !== RPC + 32'd4) begin failures++; $display("FAIL stall_skid_pc: got %b/%h expected 1/%h", fs_valid, fs_pc, RPC + 32'd4); end
      checks++; if (fs_inst !== RPC + 32'h104) begin failures++; $display("FAIL stall_skid_inst: got %h expected %h", fs_inst, RPC + 32'h104); end
      idle('0);
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1 || fs_pc !== RPC + 32'd8) begin failures++; $display("FAIL stall_resume: got %b/%h expected 1/%h", ok, fs_pc, RPC + 32'd8); end
   endtask

   task automatic test_flush_wait();
      bit ok;
      m_accept_all = 1'b1; m_cfg_delay = 2;
      do_reset();
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fw_first: got timeout expected valid"); end
      idle(6'b000010);
      step(1'b0, 6'b000010, 1'b1, FPC, 1'b0, '0);
      checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL fw_invalidate: got %b expected 0", fs_valid); end
      wait_req(20, ok);
      checks++; if (ok !== 1'b1 || bus.inst_addr !== FPC) begin failures++; $display("FAIL fw_addr: got %b/%h expected 1/%h", ok, bus.inst_addr, FPC); end
      checks++; if (m_pend !== 1'b0) begin failures++; $display("FAIL fw_outstanding: got %b expected 0", m_pend); end
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1 || fs_pc !== FPC || fs_inst !== FPC + 32'h100) begin failures++; $display("FAIL fw_target: got %h/%h expected %h/%h", fs_pc, fs_inst, FPC, FPC + 32'h100); end
   endtask

   task automatic test_branch();
      bit ok;
      logic [31:0] tgt;
      tgt = 32'h1c000040;
      m_accept_all = 1'b1; m_cfg_delay = 0;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.inst_req && bus.inst_addr == RPC + 32'd12) begin ok = 1'b1; break; end
         idle('0);
      end
      checks++; if (ok !== 1'b1 || fs_valid !== 1'b1) begin failures++; $display("FAIL br_setup: got %b/%b expected 1/1", ok, fs_valid); end
      step(1'b0, '0, 1'b0, '0, 1'b1, tgt);
      wait_req(20, ok);
      checks++; if (ok !== 1'b1 || bus.inst_addr !== tgt) begin failures++; $display("FAIL br_addr: got %b/%h expected 1/%h", ok, bus.inst_addr, tgt); end
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1 || fs_pc !== tgt || fs_inst !== tgt + 32'h100) begin failures++; $display("FAIL br_target: got %h/%h expected %h/%h", fs_pc, fs_inst, tgt, tgt + 32'h100); end
   endtask

   task automatic test_flush_pending();
      bit ok;
      m_accept_all = 1'b1; m_cfg_delay = 0;
      do_reset();
      m_block = 1'b1;
      wait_req(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fp_req: got timeout expected request"); end
      step(1'b0, '0, 1'b1, FPC, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC) begin failures++; $display("FAIL fp_hold k%0d: got %b/%h expected 1/%h", k, bus.inst_req, bus.inst_addr, RPC); end
         idle('0);
      end
      m_block = 1'b0;
      idle('0);
      wait_req(20, ok);
      checks++; if (ok !== 1'b1 || bus.inst_addr !== FPC) begin failures++; $display("FAIL fp_addr: got %b/%h expected 1/%h", ok, bus.inst_addr, FPC); end
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1 || fs_pc !== FPC) begin failures++; $display("FAIL fp_target: got %b/%h expected 1/%h", ok, fs_pc, FPC); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      m_accept_all = 1'b1; m_cfg_delay = 1;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.inst_req && bus.inst_addr == RPC + 32'd4) begin ok = 1'b1; break; end
         idle('0);
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rm_setup: got timeout expected request"); end
      idle(6'b000010);
      checks++; if (fs_valid !== 1'b1 || m_pend !== 1'b1) begin failures++; $display("FAIL rm_inflight: got %b/%b expected 1/1", fs_valid, m_pend); end
      step(1'b1, '0, 1'b0, '0, 1'b0, '0);
      checks++; if (fs_valid !== 1'b0 || bus.inst_req !== 1'b0) begin failures++; $display("FAIL rm_cleared: got %b/%b expected 0/0", fs_valid, bus.inst_req); end
      idle('0);
      checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC) begin failures++; $display("FAIL rm_first_addr: got %b/%h expected 1/%h", bus.inst_req, bus.inst_addr, RPC); end
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1 || fs_pc !== RPC || fs_inst !== RPC + 32'h100) begin failures++; $display("FAIL rm_first_inst: got %h/%h expected %h/%h", fs_pc, fs_inst, RPC, RPC + 32'h100); end
   endtask

   task automatic test_random();
      logic [5:0]  st;
      bit          fl, bt;
      logic [31:0] fpc, btgt;
      int          start;
      m_accept_all = 1'b0; m_cfg_delay = -1;
      do_reset();
      start = n_cons;
      for (int i = 0; i < 2000; i++) begin
         st = 6'($urandom);
         st[0] = ($urandom_range(0, 3) == 0);
         st[1] = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 39) == 0);
         fpc = 32'h1c010000 + 32'($urandom_range(0, 1023)) * 32'd4;
         bt  = fs_valid && ($urandom_range(0, 9) == 0);
         btgt = 32'h1c020000 + 32'($urandom_range(0, 1023)) * 32'd4;
         step(1'b0, st, fl, fpc, bt, btgt);
         checks++; if (viol_out !== 1'b0) begin failures++; $display("FAIL rnd_outstanding i%0d: got 1 expected 0", i); end
         checks++; if (viol_addr !== 1'b0) begin failures++; $display("FAIL rnd_addr_stable i%0d: got 1 expected 0", i); end
         if (cons) begin
            checks++; if (cons_pc !== cons_exp) begin failures++; $display("FAIL rnd_pc i%0d: got %h expected %h", i, cons_pc, cons_exp); end
            checks++; if (cons_inst !== cons_exp + 32'h100) begin failures++; $display("FAIL rnd_inst i%0d: got %h expected %h", i, cons_inst, cons_exp + 32'h100); end
         end
      end
      checks++; if ((n_cons - start) < 100) begin failures++; $display("FAIL rnd_progress: got %0d expected >=100", n_cons - start); end
   endtask

   initial begin
      reset = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0; br_taken = 1'b0; br_target = '0;
      bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
      m_pend = 1'b0; m_addr = '0; m_delay = 0; m_cfg_delay = 0; m_accept_all = 1'b1; m_block = 1'b0;
      prev_pend_req = 1'b0; prev_addr = '0; exp_pc = RPC;
      @(negedge clk);
      test_reset();
      test_ideal();
      test_stall();
      test_flush_wait();
      test_branch();
      test_flush_pending();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
